// File: rtl/byte_demux_pkg.sv
// Shared types and helpers for the byte-masked address-window demultiplexer.
package byte_demux_pkg;

  // Index width sized for the largest supported fan-out (8 memories).
  localparam int IDX_W = 3;

  // Widest address the window comparator handles; narrower addresses are zero-extended.
  localparam int ADDR_MAX_W = 64;

  // Routing tag carried alongside each accepted request until its response slot.
  typedef struct packed {
    logic             valid;
    logic             is_read;
    logic             err;
    logic [IDX_W-1:0] idx;
  } route_tag_t;

  // Inclusive window membership test: base <= addr <= limit.
  function automatic logic window_hit(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic [ADDR_MAX_W-1:0] base,
    input logic [ADDR_MAX_W-1:0] limit
  );
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/byte_route_pipe.sv
// Fixed-depth routing-tag shift pipeline. It advances every cycle, independent
// of downstream stalls, so the retiring tag lines up with memory read data.
module byte_route_pipe
  import byte_demux_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  route_tag_t issue_tag,
  output route_tag_t retire_tag
);

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] rd_p;
  logic [STAGES-1:0] err_p;
  logic [IDX_W-1:0]  idx_p [STAGES];

  // Stage valids: flushed by reset so outstanding requests never retire
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue_tag.valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Stage payloads: only meaningful while the matching valid is set
  always_ff @(posedge clk_i) begin
    rd_p[0]  <= issue_tag.is_read;
    err_p[0] <= issue_tag.err;
    idx_p[0] <= issue_tag.idx;
    for (int k = 1; k < STAGES; k++) begin
      rd_p[k]  <= rd_p[k-1];
      err_p[k] <= err_p[k-1];
      idx_p[k] <= idx_p[k-1];
    end
  end

  // Last stage presented as a tag
  always_comb begin
    retire_tag         = '0;
    retire_tag.valid   = vld_p[STAGES-1];
    retire_tag.is_read = rd_p[STAGES-1];
    retire_tag.err     = err_p[STAGES-1];
    retire_tag.idx     = idx_p[STAGES-1];
  end

endmodule

// File: rtl/byte_demux_window.sv
// Address-window demultiplexer: routes one byte-masked memory port to MEMS
// downstream memories, returns read data after a fixed latency and reports
// decode errors with a saturating counter.
module byte_demux_window
  import byte_demux_pkg::*;
#(
  parameter int                        MEMS         = 2,
  parameter int                        DATA_BYTE    = 4,
  parameter int                        ADDR_SIZE    = 32,
  parameter logic [ADDR_SIZE*MEMS-1:0] BASE_ADDR    = {32'h8000_0000, 32'h1000_0000},
  parameter logic [ADDR_SIZE*MEMS-1:0] LIMIT_ADDR   = {32'h8000_FFFF, 32'h1000_0FFF},
  parameter int                        READ_LATENCY = 1,
  parameter bit                        STRIP_BASE   = 1'b0,
  parameter int                        ERR_CNT_W    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          useEnable_i,
  input  logic                          useIsWrite_i,
  input  logic [DATA_BYTE-1:0]          useWriteMask_i,
  input  logic [ADDR_SIZE-1:0]          useAddr_i,
  input  logic [DATA_BYTE*8-1:0]        useWriteData_i,
  output logic [DATA_BYTE*8-1:0]        useReadData_o,
  output logic                          useReadValid_o,
  output logic                          useError_o,
  output logic                          useHold_o,
  output logic [ERR_CNT_W-1:0]          errCount_o,
  output logic [MEMS-1:0]               memEnable_o,
  output logic [MEMS-1:0]               memIsWrite_o,
  output logic [MEMS*DATA_BYTE-1:0]     memWriteMask_o,
  output logic [MEMS*ADDR_SIZE-1:0]     memAddr_o,
  output logic [MEMS*DATA_BYTE*8-1:0]   memWriteData_o,
  input  logic [MEMS*DATA_BYTE*8-1:0]   memReadData_i,
  input  logic [MEMS-1:0]               memHold_i
);

  localparam int DATA_W = DATA_BYTE * 8;

  logic [MEMS-1:0]      hit_vec;
  logic                 any_hit;
  logic [IDX_W-1:0]     sel;
  logic                 sel_hold;
  logic [ADDR_SIZE-1:0] sel_base;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic                 accept;
  route_tag_t           issue_tag;
  route_tag_t           retire_tag;
  logic [DATA_W-1:0]    ret_data;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Per-window hit flags
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < MEMS; i++) begin
      hit_vec[i] = window_hit(ADDR_MAX_W'(useAddr_i),
                              ADDR_MAX_W'(BASE_ADDR[ADDR_SIZE*i +: ADDR_SIZE]),
                              ADDR_MAX_W'(LIMIT_ADDR[ADDR_SIZE*i +: ADDR_SIZE]));
    end
  end

  // Priority select: scanning downward leaves the lowest hitting index
  always_comb begin
    sel      = '0;
    sel_hold = 1'b0;
    sel_base = '0;
    for (int i = MEMS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel      = IDX_W'(i);
        sel_hold = memHold_i[i];
        sel_base = BASE_ADDR[ADDR_SIZE*i +: ADDR_SIZE];
      end
    end
  end

  assign any_hit   = |hit_vec;
  // A hit guarantees addr >= base, so the subtraction cannot underflow
  assign sel_addr  = STRIP_BASE ? (useAddr_i - sel_base) : useAddr_i;
  assign useHold_o = useEnable_i & any_hit & sel_hold;
  assign accept    = useEnable_i & ~useHold_o;

  // Request fan-out: only the selected memory sees the request fields
  always_comb begin
    memEnable_o    = '0;
    memIsWrite_o   = '0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    for (int i = 0; i < MEMS; i++) begin
      if (any_hit && (sel == IDX_W'(i))) begin
        memEnable_o[i]                            = useEnable_i;
        memIsWrite_o[i]                           = useIsWrite_i;
        memWriteMask_o[DATA_BYTE*i +: DATA_BYTE]  = useWriteMask_i;
        memAddr_o[ADDR_SIZE*i +: ADDR_SIZE]       = sel_addr;
        memWriteData_o[DATA_W*i +: DATA_W]        = useWriteData_i;
      end
    end
  end

  // Tag for this cycle; a non-accepted cycle issues an empty tag
  always_comb begin
    issue_tag         = '0;
    issue_tag.valid   = accept;
    issue_tag.is_read = ~useIsWrite_i;
    issue_tag.err     = ~any_hit;
    issue_tag.idx     = sel;
  end

  byte_route_pipe #(
    .STAGES (READ_LATENCY)
  ) u_route_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_tag  (issue_tag),
    .retire_tag (retire_tag)
  );

  // Response fan-in: pick read data of the memory the retiring tag points at
  always_comb begin
    ret_data = '0;
    for (int i = 0; i < MEMS; i++) begin
      if (retire_tag.idx == IDX_W'(i)) begin
        ret_data = memReadData_i[DATA_W*i +: DATA_W];
      end
    end
  end

  // Response strobes; errored responses carry zero data
  always_comb begin
    useReadValid_o = retire_tag.valid & retire_tag.is_read;
    useError_o     = retire_tag.valid & retire_tag.err;
    useReadData_o  = '0;
    if (retire_tag.valid && retire_tag.is_read && !retire_tag.err) begin
      useReadData_o = ret_data;
    end
  end

  // Decode-error counter, counted at acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (accept && !any_hit) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign errCount_o = err_cnt;

endmodule
